// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - instruction store, fetch/decode and PC sequencing for the control unit
module instr_issue_unit #(
    parameter int          PC_WIDTH  = 8,
    parameter int          MAX_WAIT  = 16,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic                Run,
    input  logic                load_en,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic [31:0]         load_data,
    input  logic                pc_write,
    input  logic                Pcsrc,
    input  logic                jump,
    output logic [5:0]          opcode,
    output logic [5:0]          funct,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [15:0]         imm16,
    output logic                Run_ctl,
    output logic                issue_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t              state, state_nxt;
    logic [31:0]         mem [0:(1 << PC_WIDTH) - 1];
    logic [31:0]         rd_data;
    logic [31:0]         instr_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [PC_WIDTH-1:0] pc_seq, pc_br, pc_jmp, next_pc;

    // Store is deliberately not reset so a program survives Reset.
    always_ff @(posedge CLOCK_50) begin
        if (load_en && (state == S_IDLE || state == S_HALT)) begin
            mem[load_addr] <= load_data;
        end
        if (state == S_FETCH) begin
            rd_data <= mem[pc];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Run && !load_en) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (rd_data == HALT_WORD) ? S_HALT : S_WAIT;
            S_WAIT:  if (pc_write) state_nxt = Run ? S_FETCH : S_IDLE;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Branch offset is sign-extended then wrapped to the PC width.
    always_comb begin
        pc_seq  = pc + PC_WIDTH'(1);
        pc_br   = pc + PC_WIDTH'(1) + PC_WIDTH'($signed(instr_q[15:0]));
        pc_jmp  = PC_WIDTH'(instr_q[25:0]);
        next_pc = jump ? pc_jmp : (Pcsrc ? pc_br : pc_seq);
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            pc          <= '0;
            instr_q     <= '0;
            issue_valid <= 1'b0;
            Run_ctl     <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            issue_valid <= 1'b0;
            case (state)
                S_ISSUE: begin
                    if (rd_data == HALT_WORD) begin
                        halted <= 1'b1;
                    end else begin
                        instr_q     <= rd_data;
                        issue_valid <= 1'b1;
                        Run_ctl     <= 1'b1;
                        wait_cnt    <= '0;
                    end
                end
                S_WAIT: begin
                    if (pc_write) begin
                        pc       <= next_pc;
                        Run_ctl  <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != CNT_W'(MAX_WAIT)) begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                        if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];
    assign imm16  = instr_q[15:0];

endmodule
